y86_mem_bridge: RTL and testbench

Y86_MEM_BRIDGE -- requirements
Module: y86_mem_bridge

---
 rtl/y86_mem_bridge.sv | 197 +++++++++++++++++++
 tb/tb_y86_mem_bridge.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_bridge.sv
// Bridges a byte-addressed Y86 CPU bus onto a 32-bit word SRAM. Unaligned
// 32-bit accesses are split into two word accesses (lo word, then hi word).
module y86_mem_bridge #(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_A,
  input  logic              bus_RE,
  input  logic              bus_WE,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    RD_FIN = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [MEM_AW-1:0] WORD_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [MEM_AW-1:0] w_r;
  logic [1:0]        o_r;
  logic [31:0]       wdata_r;
  logic [31:0]       lo_r;

  // Address bits above the SRAM range carry no meaning for this bridge.
  logic unused_addr;
  assign unused_addr = ^bus_A[31:MEM_AW+2];

  function automatic logic [3:0] lo_be(input logic [1:0] o);
    case (o)
      2'd0:    lo_be = 4'b1111;
      2'd1:    lo_be = 4'b1110;
      2'd2:    lo_be = 4'b1100;
      2'd3:    lo_be = 4'b1000;
      default: lo_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] hi_be(input logic [1:0] o);
    case (o)
      2'd1:    hi_be = 4'b0001;
      2'd2:    hi_be = 4'b0011;
      2'd3:    hi_be = 4'b0111;
      default: hi_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lo_data(input logic [31:0] d, input logic [1:0] o);
    case (o)
      2'd0:    lo_data = d;
      2'd1:    lo_data = {d[23:0], 8'h00};
      2'd2:    lo_data = {d[15:0], 16'h0000};
      2'd3:    lo_data = {d[7:0], 24'h000000};
      default: lo_data = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] hi_data(input logic [31:0] d, input logic [1:0] o);
    case (o)
      2'd1:    hi_data = {24'h000000, d[31:24]};
      2'd2:    hi_data = {16'h0000, d[31:16]};
      2'd3:    hi_data = {8'h00, d[31:8]};
      default: hi_data = 32'h0000_0000;
    endcase
  endfunction

  // Extract the 32-bit little-endian word starting at byte o of {hi,lo}.
  function automatic logic [31:0] align(input logic [31:0] hi, input logic [31:0] lo,
                                        input logic [1:0] o);
    case (o)
      2'd1:    align = {hi[7:0], lo[31:8]};
      2'd2:    align = {hi[15:0], lo[31:16]};
      2'd3:    align = {hi[23:0], lo[31:24]};
      default: align = lo;
    endcase
  endfunction

  // Access sequencer: every bus and SRAM output is a register of this FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      w_r       <= '0;
      o_r       <= 2'd0;
      wdata_r   <= 32'h0000_0000;
      lo_r      <= 32'h0000_0000;
      bus_rdata <= 32'h0000_0000;
      bus_ready <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          bus_ready <= 1'b0;
          // A write wins when both strobes are raised together.
          if (bus_WE) begin
            w_r       <= bus_A[MEM_AW+1:2];
            o_r       <= bus_A[1:0];
            wdata_r   <= bus_wdata;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= bus_A[MEM_AW+1:2];
            mem_be    <= lo_be(bus_A[1:0]);
            mem_wdata <= lo_data(bus_wdata, bus_A[1:0]);
            busy      <= 1'b1;
            state_r   <= WR_LO;
          end else if (bus_RE) begin
            w_r      <= bus_A[MEM_AW+1:2];
            o_r      <= bus_A[1:0];
            wdata_r  <= bus_wdata;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= bus_A[MEM_AW+1:2];
            mem_be   <= 4'b1111;
            busy     <= 1'b1;
            state_r  <= RD_LO;
          end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RD_LO: begin
          if (o_r != 2'd0) begin
            mem_addr <= w_r + WORD_ONE;
            state_r  <= RD_HI;
          end else begin
            mem_en  <= 1'b0;
            state_r <= RD_FIN;
          end
        end
        RD_HI: begin
          lo_r    <= mem_rdata;
          mem_en  <= 1'b0;
          state_r <= RD_FIN;
        end
        RD_FIN: begin
          bus_rdata <= (o_r == 2'd0) ? mem_rdata : align(mem_rdata, lo_r, o_r);
          bus_ready <= 1'b1;
          state_r   <= DONE;
        end
        WR_LO: begin
          if (o_r != 2'd0) begin
            mem_addr  <= w_r + WORD_ONE;
            mem_be    <= hi_be(o_r);
            mem_wdata <= hi_data(wdata_r, o_r);
            state_r   <= WR_HI;
          end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            bus_ready <= 1'b1;
            state_r   <= DONE;
          end
        end
        WR_HI: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          bus_ready <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          bus_ready <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          bus_ready <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_mem_bridge.sv
// Scoreboard bench for y86_mem_bridge: a byte-array reference memory predicts
// read data, latency and SRAM strobes; a negedge monitor checks completions.
module tb_y86_mem_bridge;
  localparam int AW     = 14;
  localparam int NWORDS = 1 << AW;
  localparam int NBYTES = NWORDS * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   bus_A, bus_wdata, bus_rdata;
  logic          bus_RE, bus_WE, bus_ready, busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  y86_mem_bridge #(.MEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned cyc; logic [31:0] data; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [3:0] be; logic [31:0] data; } stb_t;

  exp_t        exp_q[$];
  stb_t        stb_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  logic [31:0] last_rd = 32'h0;

  // SRAM model; words never written read as a fixed address hash.
  logic [31:0]   sram   [NWORDS];
  logic          sram_v [NWORDS] = '{default: 1'b0};
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = 32'h0;
  logic [7:0]    gmem [NBYTES];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
    return sram_v[a] ? sram[a] : init_word(int'(a));
  endfunction

  always @(posedge clk) begin
    logic [31:0] cur;
    cyc <= cyc + 1;
    if (pl_en) begin
      sram[pl_addr]   <= pl_data;
      sram_v[pl_addr] <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        cur = sram_word(mem_addr);
        for (int l = 0; l < 4; l++)
          if (mem_be[l]) cur[8*l +: 8] = mem_wdata[8*l +: 8];
        sram[mem_addr]   <= cur;
        sram_v[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= sram_word(mem_addr);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: completions are popped from the scoreboard, strobes are logged.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) check("we_without_en", {63'b0, mem_en}, 64'd1);
    if (bus_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
        check("rdata", {32'h0, bus_rdata}, {32'h0, e.data});
      end
    end
    if (mem_en) stb_q.push_back('{addr: mem_addr, we: mem_we, be: mem_be, data: mem_wdata});
  end

  function automatic logic [31:0] model_read(input logic [15:0] b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = gmem[(int'(b) + k) % NBYTES];
    return r;
  endfunction

  task automatic gwrite(input logic [15:0] b, input logic [31:0] d);
    for (int k = 0; k < 4; k++) gmem[(int'(b) + k) % NBYTES] = d[8*k +: 8];
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = AW'(w); pl_data = v;
    gwrite(16'(w * 4), v);
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic junk();
    if ($urandom_range(0, 1) == 1) begin
      bus_RE = 1'($urandom_range(0, 1)); bus_WE = 1'($urandom_range(0, 1));
      bus_A = $urandom; bus_wdata = $urandom;
    end else begin
      bus_RE = 1'b0; bus_WE = 1'b0;
    end
  endtask

  // Issue one request in an idle cycle, fire ignored requests while it runs,
  // then compare the SRAM strobes it produced with the byte-level prediction.
  task automatic do_req(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [15:0] b;
    int lat, nstb, w0, ad, idx;
    stb_t es[2];
    exp_t e;
    b = a[15:0];
    w0 = int'(b) / 4;
    nstb = (b[1:0] != 2'd0) ? 2 : 1;
    es[0] = '{addr: AW'(w0), we: we, be: 4'b0, data: 32'h0};
    es[1] = '{addr: AW'((w0 + 1) % NWORDS), we: we, be: 4'b0, data: 32'h0};
    if (we) begin
      lat = (b[1:0] != 2'd0) ? 3 : 2;
      for (int k = 0; k < 4; k++) begin
        ad = (int'(b) + k) % NBYTES;
        idx = (ad / 4 == w0) ? 0 : 1;
        es[idx].be[ad % 4] = 1'b1;
        es[idx].data[8*(ad % 4) +: 8] = d[8*k +: 8];
      end
      gwrite(b, d);
    end else begin
      lat = (b[1:0] != 2'd0) ? 4 : 3;
      es[0].be = 4'hF; es[1].be = 4'hF;
      last_rd = model_read(b);
    end
    e.cyc = cyc + lat; e.data = last_rd;
    exp_q.push_back(e);
    stb_q.delete();
    bus_RE = re; bus_WE = we; bus_A = a; bus_wdata = d;
    @(posedge clk); #1;
    for (int i = 0; i < lat; i++) begin
      junk();
      @(posedge clk); #1;
    end
    bus_RE = 1'b0; bus_WE = 1'b0;
    check("strobe_count", 64'(stb_q.size()), 64'(nstb));
    for (int i = 0; i < nstb && i < stb_q.size(); i++) begin
      check("strobe_addr", 64'(stb_q[i].addr), 64'(es[i].addr));
      check("strobe_we", 64'(stb_q[i].we), 64'(es[i].we));
      check("strobe_be", 64'(stb_q[i].be), 64'(es[i].be));
      if (we) check("strobe_wdata", 64'(stb_q[i].data), 64'(es[i].data));
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int op, bad;
    rst = 1'b1; bus_RE = 1'b0; bus_WE = 1'b0; bus_A = 32'h0; bus_wdata = 32'h0;
    for (int i = 0; i < NWORDS; i++)
      for (int k = 0; k < 4; k++) gmem[4*i + k] = init_word(i) >> (8*k);
    @(posedge clk); #1;
    poke(5, 32'h1122_3344);
    poke(6, 32'hAABB_CCDD);
    @(posedge clk); #1;
    check("rst_bus_rdata", 64'(bus_rdata), 64'd0);
    check("rst_bus_ready", 64'(bus_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;

    // Directed cases: aligned/unaligned read, unaligned write, wrap, collisions.
    do_req(1'b1, 1'b0, 32'h0000_0014, 32'h0);
    do_req(1'b1, 1'b0, 32'h0000_0017, 32'h0);
    do_req(1'b0, 1'b1, 32'h0000_0016, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h0000_0014, 32'h0);
    do_req(1'b1, 1'b0, 32'h0000_FFFD, 32'h0);
    do_req(1'b1, 1'b1, 32'h0000_0101, 32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    do_req(1'b0, 1'b1, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 32'h0000_FFFF, 32'h0);

    // Reset during the second half of an unaligned write.
    d = $urandom;
    bus_WE = 1'b1; bus_A = 32'h0000_0202; bus_wdata = d;
    gwrite(16'h0202, d);
    @(posedge clk); #1;
    bus_WE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd = 32'h0;
    check("abort_mem_en", 64'(mem_en), 64'd0);
    check("abort_mem_we", 64'(mem_we), 64'd0);
    check("abort_bus_ready", 64'(bus_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_bus_rdata", 64'(bus_rdata), 64'd0);
    do_req(1'b1, 1'b0, 32'h0000_0203, 32'h0);

    // Random traffic, concentrated on a small window so reads see earlier writes.
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(16'hFFF0, 16'hFFFF));
        default: a = 32'($urandom_range(0, 63));
      endcase
      d = $urandom;
      do_req(op != 1, op != 0, a, d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (10) @(posedge clk);
    #1;
    check("pending_ready", 64'(exp_q.size()), 64'd0);
    bad = 0;
    for (int i = 0; i < NWORDS; i++)
      if (sram_word(AW'(i)) !== {gmem[4*i+3], gmem[4*i+2], gmem[4*i+1], gmem[4*i]}) bad++;
    check("sram_contents", 64'(bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
